// File: rtl/vga_plot_sink.sv
// vga_plot_sink: 160x120x3 frame buffer with a pixel-write port and a
// 640x480 VGA scan-out. Each stored pixel is shown as a 4x4 block.
// Optional build macro CLEAR_ON_RESET_EN: after reset the buffer is swept
// to zero, one address per clk, while busy is held high.
module vga_plot_sink #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       plot,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   output logic       busy,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] VGA_R,
   output logic [9:0] VGA_G,
   output logic [9:0] VGA_B
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_VIS);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VIS + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_VIS + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_VIS);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VIS + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_VIS + V_FP + V_SYNC);

   localparam logic [14:0] FB_LAST  = 15'd19199;
   localparam logic [14:0] FB_WIDTH = 15'd160;

   logic            r_pix_en;
   logic [HW-1:0]   r_hcount;
   logic [VW-1:0]   r_vcount;

   logic            w_vis;
   logic            w_hs;
   logic            w_vs;
   logic [14:0]     w_rd_addr;
   logic [14:0]     w_pl_addr;
   logic            w_pl_ok;

   logic            w_we;
   logic [14:0]     w_wr_addr;
   logic [2:0]      w_wr_data;

   logic [2:0]      r_fb [0:19199];
   logic [2:0]      r_rd_data;
   logic            r_hs;
   logic            r_vs;
   logic            r_blank_n;

   // Divide clk by two to get the 25 MHz pixel enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_en <= 1'b0;
      end else begin
         r_pix_en <= ~r_pix_en;
      end
   end

   // Raster counters: hcount steps each pixel, vcount steps on hcount wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end else if (r_pix_en) begin
         if (r_hcount == H_LAST) begin
            r_hcount <= '0;
            if (r_vcount == V_LAST) begin
               r_vcount <= '0;
            end else begin
               r_vcount <= r_vcount + VW'(1);
            end
         end else begin
            r_hcount <= r_hcount + HW'(1);
         end
      end
   end

   // Decode visibility and sync pulses for the current raster position
   always_comb begin
      w_vis = (r_hcount < H_VIS_END) && (r_vcount < V_VIS_END);
      w_hs  = !((r_hcount >= H_SYNC_BEG) && (r_hcount < H_SYNC_END));
      w_vs  = !((r_vcount >= V_SYNC_BEG) && (r_vcount < V_SYNC_END));
   end

   // Scan read address; blanking positions map to 0 to stay inside the buffer
   always_comb begin
      w_rd_addr = 15'd0;
      if (w_vis) begin
         w_rd_addr = 15'(r_vcount >> 2) * FB_WIDTH + 15'(r_hcount >> 2);
      end else begin
         w_rd_addr = 15'd0;
      end
   end

   // Plot address and range qualification
   always_comb begin
      w_pl_ok   = (x < 8'd160) && (y < 7'd120);
      w_pl_addr = 15'(y) * FB_WIDTH + 15'(x);
   end

`ifdef CLEAR_ON_RESET_EN
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [0:0]  r_state;
   logic [14:0] r_clr_addr;
   logic        r_busy;

   // Clear sweep: reset parks the FSM in CLEAR at address 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= 15'd0;
         r_busy     <= 1'b1;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_clr_addr == FB_LAST) begin
                  r_state    <= ST_IDLE;
                  r_clr_addr <= 15'd0;
                  r_busy     <= 1'b0;
               end else begin
                  r_clr_addr <= r_clr_addr + 15'd1;
               end
            end
            ST_IDLE: begin
               r_busy <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Single write port: the clear sweep owns it while busy, plots otherwise
   always_comb begin
      w_we      = 1'b0;
      w_wr_addr = w_pl_addr;
      w_wr_data = colour;
      if (r_state == ST_CLEAR) begin
         w_we      = 1'b1;
         w_wr_addr = r_clr_addr;
         w_wr_data = 3'b000;
      end else begin
         w_we      = plot & w_pl_ok & ~r_busy;
         w_wr_addr = w_pl_addr;
         w_wr_data = colour;
      end
   end

   assign busy = r_busy;
`else
   // Write port driven straight from the plot interface
   always_comb begin
      w_we      = plot & w_pl_ok;
      w_wr_addr = w_pl_addr;
      w_wr_data = colour;
   end

   assign busy = 1'b0;
`endif

   // Frame buffer write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_fb[w_wr_addr] <= w_wr_data;
      end
   end

   // Scan read, one pixel of latency; same-address writes return old data
   always_ff @(posedge clk) begin
      if (r_pix_en) begin
         r_rd_data <= r_fb[w_rd_addr];
      end
   end

   // Delay sync and blank by the read latency so they line up with colour
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
         r_blank_n <= 1'b0;
      end else if (r_pix_en) begin
         r_hs      <= w_hs;
         r_vs      <= w_vs;
         r_blank_n <= w_vis;
      end
   end

   assign VGA_CLK     = r_pix_en;
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b1;
   assign VGA_R       = r_blank_n ? {10{r_rd_data[2]}} : 10'h000;
   assign VGA_G       = r_blank_n ? {10{r_rd_data[1]}} : 10'h000;
   assign VGA_B       = r_blank_n ? {10{r_rd_data[0]}} : 10'h000;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink using a reduced raster so whole frames
// fit in a short run. A cycle model of the raster and buffer supplies the
// expected output of every pixel clock; directed checks cover the named cases.
module tb_vga_plot_sink;

   localparam int H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
   localparam int V_VIS = 16, V_FP = 2, V_SYNC = 2, V_BP = 4;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 56
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 24
   localparam int FRAME_CLK = 2 * H_TOT * V_TOT;          // 2688

   logic       clk, reset_n, plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       busy, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [9:0] VGA_R, VGA_G, VGA_B;

   vga_plot_sink #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .plot(plot), .x(x), .y(y), .colour(colour),
      .busy(busy), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [2:0] mm [0:19199] = '{default: 3'b000};
   logic       m_pix, e_hs, e_vs, e_bl;
   logic [2:0] e_rgb;
   int         m_h, m_v, o_h, o_v, m_busy_cnt;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pix <= 1'b0; m_h <= 0; m_v <= 0; o_h <= 0; o_v <= 0;
         e_hs <= 1'b1; e_vs <= 1'b1; e_bl <= 1'b0; e_rgb <= 3'b000;
`ifdef CLEAR_ON_RESET_EN
         m_busy_cnt <= 19200;
`else
         m_busy_cnt <= 0;
`endif
      end else begin
         m_pix <= ~m_pix;
         if (m_pix) begin
            e_bl  <= (m_h < H_VIS) && (m_v < V_VIS);
            e_hs  <= !((m_h >= H_VIS + H_FP) && (m_h < H_VIS + H_FP + H_SYNC));
            e_vs  <= !((m_v >= V_VIS + V_FP) && (m_v < V_VIS + V_FP + V_SYNC));
            e_rgb <= ((m_h < H_VIS) && (m_v < V_VIS)) ? mm[(m_v / 4) * 160 + m_h / 4] : 3'b000;
            o_h   <= m_h;
            o_v   <= m_v;
            if (m_h == H_TOT - 1) begin
               m_h <= 0;
               m_v <= (m_v == V_TOT - 1) ? 0 : m_v + 1;
            end else begin
               m_h <= m_h + 1;
            end
         end
         if (m_busy_cnt > 0) begin
            mm[19200 - m_busy_cnt] <= 3'b000;
            m_busy_cnt <= m_busy_cnt - 1;
         end else if (plot && x < 8'd160 && y < 7'd120) begin
            mm[int'(y) * 160 + int'(x)] <= colour;
         end
      end
   end

   // ---------------- negedge sampling ----------------
   logic scan_en = 1'b0, stat_en = 1'b0, dir_en = 1'b0;
   int   snap_mode = 0;
   int   n_hs, n_vs, n_bl, n_white, n_blank_rgb, n_vis_nz, n_blk, n_nbr, n_cmp, n_diff;
   logic [2:0] snap [0:H_VIS*V_VIS-1];

   always @(negedge clk) begin
      if (scan_en)
         check("scan", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, busy, VGA_CLK, VGA_SYNC_N},
               {e_hs, e_vs, e_bl, {10{e_rgb[2]}}, {10{e_rgb[1]}}, {10{e_rgb[0]}},
                (m_busy_cnt != 0), m_pix, 1'b1});
      if (stat_en) begin
         if (!VGA_HS) n_hs++;
         if (!VGA_VS) n_vs++;
         if (VGA_BLANK_N) n_bl++;
         if (e_bl && VGA_R == 10'h3FF && VGA_G == 10'h3FF && VGA_B == 10'h3FF) n_white++;
         if (!e_bl && (VGA_R | VGA_G | VGA_B) != 10'h000) n_blank_rgb++;
         if (e_bl && (VGA_R | VGA_G | VGA_B) != 10'h000) n_vis_nz++;
      end
      if (dir_en && e_bl && o_v >= 12 && o_v <= 15) begin
         if (o_h >= 20 && o_h <= 23) begin
            check("blk", {VGA_R, VGA_G, VGA_B}, {10'h3FF, 10'h000, 10'h3FF});
            n_blk++;
         end else if ((o_h >= 16 && o_h <= 19) || (o_h >= 24 && o_h <= 27)) begin
            check("nbr", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h3FF, 10'h000});
            n_nbr++;
         end
      end
      if (snap_mode == 1 && e_bl)
         snap[o_v * H_VIS + o_h] <= {VGA_R[0], VGA_G[0], VGA_B[0]};
      if (snap_mode == 2 && e_bl) begin
         n_cmp++;
         if (snap[o_v * H_VIS + o_h] != {VGA_R[0], VGA_G[0], VGA_B[0]}) n_diff++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic plot_px(input int px, input int py, input logic [2:0] c);
      plot = 1'b1; x = 8'(px); y = 7'(py); colour = c;
      tick(1);
      plot = 1'b0;
   endtask

   task automatic fill_visible(input logic [2:0] c);
      for (int yy = 0; yy < V_VIS / 4; yy++)
         for (int xx = 0; xx < H_VIS / 4; xx++)
            plot_px(xx, yy, c);
   endtask

   task automatic clear_stats();
      n_hs = 0; n_vs = 0; n_bl = 0; n_white = 0; n_blank_rgb = 0;
      n_vis_nz = 0; n_blk = 0; n_nbr = 0; n_cmp = 0; n_diff = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int cnt;
      int guard;
      reset_n = 1'b0; plot = 1'b0; x = 8'd0; y = 7'd0; colour = 3'b000;
      clear_stats();
      tick(3);

      // power-on reset values
      check("rst_out", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_SYNC_N},
            {1'b1, 1'b1, 1'b0, 30'd0, 1'b0, 1'b1});
`ifdef CLEAR_ON_RESET_EN
      check("rst_busy", busy, 1'b1);
      reset_n = 1'b1;
      cnt = 0;
      while (busy && cnt < 20000) begin
         cnt++;
         if (cnt == 100) begin
            plot = 1'b1; x = 8'd0; y = 7'd0; colour = 3'b010;
         end else begin
            plot = 1'b0;
         end
         tick(1);
      end
      plot = 1'b0;
      check("busy_len", cnt, 19200);
      scan_en = 1'b1; clear_stats(); stat_en = 1'b1;
      tick(FRAME_CLK);
      stat_en = 1'b0;
      check("clear_zero", n_vis_nz, 0);
`else
      check("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      #1 check("busy_low", busy, 1'b0);
`endif

      // fill with green, then raster timing over exactly one frame
      fill_visible(3'b010);
      scan_en = 1'b1;
      tick(3);
      clear_stats(); stat_en = 1'b1;
      tick(FRAME_CLK);
      stat_en = 1'b0;
      check("hs_low_clk", n_hs, 2 * H_SYNC * V_TOT);   // 384
      check("vs_low_clk", n_vs, 2 * H_TOT * V_SYNC);   // 224
      check("blank_hi",   n_bl, 2 * H_VIS * V_VIS);    // 1280

      // write one pixel and read it back as a 4x4 block
      plot_px(5, 3, 3'b101);
      tick(2);
      clear_stats(); dir_en = 1'b1;
      tick(FRAME_CLK);
      dir_en = 1'b0;
      check("blk_hits", n_blk, 32);
      check("nbr_hits", n_nbr, 64);

      // out-of-range writes must not change the picture
      snap_mode = 1;
      tick(FRAME_CLK);
      snap_mode = 0;
      plot_px(160, 0, 3'b111);
      plot_px(0, 120, 3'b111);
      tick(2);
      clear_stats(); snap_mode = 2;
      tick(FRAME_CLK);
      snap_mode = 0;
      check("oor_diff", n_diff, 0);
      check("oor_cmp",  n_cmp, 2 * H_VIS * V_VIS);

      // all-white buffer: colour only inside the visible area
      fill_visible(3'b111);
      tick(2);
      clear_stats(); stat_en = 1'b1;
      tick(FRAME_CLK);
      stat_en = 1'b0;
      check("blank_rgb", n_blank_rgb, 0);
      check("vis_white", n_white, 2 * H_VIS * V_VIS);

      // reset mid-frame
      guard = 0;
      while (!(o_v == 10 && e_bl) && guard < FRAME_CLK) begin
         tick(1);
         guard++;
      end
      check("mid_found", guard < FRAME_CLK, 1'b1);
      check("mid_pre_bl", VGA_BLANK_N, 1'b1);
      reset_n = 1'b0;
      #1 check("mid_rst", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, VGA_CLK},
                {1'b1, 1'b1, 1'b0, 30'd0, 1'b0});
      tick(3);
      reset_n = 1'b1;
      tick(1);
      check("restart_e1", VGA_BLANK_N, 1'b0);
      tick(1);
      check("restart_e2", VGA_BLANK_N, 1'b1);
      tick(FRAME_CLK);

      scan_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
